// File: rtl/strip_id_sequencer.sv
// ============================================================================
// Module   : strip_id_sequencer
// Brief    : Reads a priority row of strip-ID candidates for a height
//            address and emits the valid ones, one per handshake, in
//            slot order (slot 0 first). Ends every completed sequence with
//            a one-cycle done pulse; miss qualifies done when the row held
//            no valid candidate.
// Options  : `define STRIP_TABLE_WR_EN to turn the lookup table into
//            writable registers (adds the tbl_wr_* ports).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module strip_id_sequencer #(
    parameter int              ID_W     = 4,
    parameter int              NUM_CAND = 3,
    parameter int              NUM_ADDR = 10,
    parameter int              ADDR_W   = 4,
    parameter logic [ID_W-1:0] INV_CODE = 4'hD,
    localparam int             SLOT_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
    localparam int             ROW_W    = NUM_CAND * ID_W
) (
    input  logic              clk,
    input  logic              rst,
`ifdef STRIP_TABLE_WR_EN
    input  logic              tbl_wr_en_i,
    input  logic [ADDR_W-1:0] tbl_wr_addr_i,
    input  logic [ROW_W-1:0]  tbl_wr_data_i,
`endif
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_ready_o,
    input  logic              abort_i,
    output logic              cand_valid_o,
    input  logic              cand_ready_i,
    output logic [ID_W-1:0]   cand_id_o,
    output logic [SLOT_W-1:0] cand_slot_o,
    output logic              cand_last_o,
    output logic              done_o,
    output logic              miss_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_EMIT   = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    state_t              state_q;

    // Latched request address and the row buffer captured in LOOKUP.
    logic [ADDR_W-1:0]   addr_q;
    logic [ROW_W-1:0]    row_q;
    logic [ROW_W-1:0]    row_d;

    // Registered outputs.
    logic                req_ready_q;
    logic                cand_valid_q;
    logic [ID_W-1:0]     cand_id_q;
    logic [SLOT_W-1:0]   cand_slot_q;
    logic                cand_last_q;
    logic                done_q;
    logic                miss_q;

    // Slot scanner: first valid slot at or after scan_start, plus whether
    // any further valid slot follows it (drives cand_last).
    logic [ROW_W-1:0]    scan_row;
    int                  scan_start;
    logic [ID_W-1:0]     scan_code;
    logic                nxt_found_d;
    logic [SLOT_W-1:0]   nxt_slot_d;
    logic [ID_W-1:0]     nxt_id_d;
    logic                nxt_more_d;

    // ------------------------------------------------------------------------
    // Default table contents. Slot 0 is the most significant ID_W field.
    // Rows outside 0..9 (and any row at or beyond NUM_ADDR, which is never
    // selected) read as all-invalid. Contents are laid out for the default
    // 3 x 4-bit geometry.
    // ------------------------------------------------------------------------
    function automatic logic [ROW_W-1:0] default_row(input int a);
        case (a)
            0:       default_row = ROW_W'(12'h97D);
            1:       default_row = ROW_W'(12'h75D);
            2:       default_row = ROW_W'(12'h53D);
            3:       default_row = ROW_W'(12'h301);
            4:       default_row = ROW_W'(12'h012);
            5:       default_row = ROW_W'(12'h24D);
            6:       default_row = ROW_W'(12'h46D);
            7:       default_row = ROW_W'(12'h68D);
            8:       default_row = ROW_W'(12'h8DD);
            9:       default_row = ROW_W'(12'hABC);
            default: default_row = {NUM_CAND{INV_CODE}};
        endcase
    endfunction

`ifdef STRIP_TABLE_WR_EN
    // ------------------------------------------------------------------------
    // Writable table. A write lands at the clock edge, so a LOOKUP in the
    // same cycle still sees the old row; writes past NUM_ADDR match no row
    // and are dropped.
    // ------------------------------------------------------------------------
    logic [ROW_W-1:0] tbl_q [NUM_ADDR];

    // Table registers: reload defaults on reset, otherwise accept writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ADDR; a++) begin
                tbl_q[a] <= default_row(a);
            end
        end else begin
            for (int a = 0; a < NUM_ADDR; a++) begin
                if (tbl_wr_en_i && (tbl_wr_addr_i == ADDR_W'(a))) begin
                    tbl_q[a] <= tbl_wr_data_i;
                end
            end
        end
    end
`endif

    // Table read for the latched address; unmatched addresses read invalid.
    always_comb begin
        row_d = {NUM_CAND{INV_CODE}};
        for (int a = 0; a < NUM_ADDR; a++) begin
            if (addr_q == ADDR_W'(a)) begin
`ifdef STRIP_TABLE_WR_EN
                row_d = tbl_q[a];
`else
                row_d = default_row(a);
`endif
            end
        end
    end

    // Slot scan: LOOKUP searches the fresh table row from slot 0, EMIT
    // searches the row buffer after the slot currently on the output, so
    // invalid slots are skipped without a bubble cycle.
    always_comb begin
        scan_row    = (state_q == ST_LOOKUP) ? row_d : row_q;
        scan_start  = (state_q == ST_LOOKUP) ? 0 : (int'(cand_slot_q) + 1);
        scan_code   = '0;
        nxt_found_d = 1'b0;
        nxt_slot_d  = '0;
        nxt_id_d    = '0;
        nxt_more_d  = 1'b0;
        for (int s = 0; s < NUM_CAND; s++) begin
            scan_code = scan_row[(NUM_CAND-1-s)*ID_W +: ID_W];
            if ((s >= scan_start) && (scan_code != INV_CODE)) begin
                if (!nxt_found_d) begin
                    nxt_found_d = 1'b1;
                    nxt_slot_d  = SLOT_W'(s);
                    nxt_id_d    = scan_code;
                end else begin
                    nxt_more_d  = 1'b1;
                end
            end
        end
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            row_q        <= '0;
            req_ready_q  <= 1'b1;
            cand_valid_q <= 1'b0;
            cand_id_q    <= '0;
            cand_slot_q  <= '0;
            cand_last_q  <= 1'b0;
            done_q       <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless re-armed below.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // abort is meaningless here and deliberately ignored.
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_LOOKUP;
                    end
                end

                ST_LOOKUP: begin
                    if (abort_i) begin
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        row_q <= row_d;
                        if (nxt_found_d) begin
                            cand_valid_q <= 1'b1;
                            cand_id_q    <= nxt_id_d;
                            cand_slot_q  <= nxt_slot_d;
                            cand_last_q  <= !nxt_more_d;
                            miss_q       <= 1'b0;
                            state_q      <= ST_EMIT;
                        end else begin
                            done_q       <= 1'b1;
                            miss_q       <= 1'b1;
                            state_q      <= ST_FIN;
                        end
                    end
                end

                ST_EMIT: begin
                    // abort beats a simultaneous handshake: the consumer
                    // keeps the candidate, but the sequence ends silently.
                    if (abort_i) begin
                        cand_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (cand_ready_i) begin
                        if (cand_last_q) begin
                            cand_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                            miss_q       <= 1'b0;
                            state_q      <= ST_FIN;
                        end else begin
                            cand_id_q    <= nxt_id_d;
                            cand_slot_q  <= nxt_slot_d;
                            cand_last_q  <= !nxt_more_d;
                        end
                    end
                end

                ST_FIN: begin
                    // done is high this cycle; clear the qualifier with it.
                    miss_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    cand_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign cand_valid_o = cand_valid_q;
    assign cand_id_o    = cand_id_q;
    assign cand_slot_o  = cand_slot_q;
    assign cand_last_o  = cand_last_q;
    assign done_o       = done_q;
    assign miss_o       = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_strip_id_sequencer.sv
// ============================================================================
// Module   : tb_strip_id_sequencer
// Brief    : Self-checking bench for strip_id_sequencer. A cycle-by-cycle
//            vector table covers the directed scenarios; hand-written
//            sequences cover reset mid-emit, random back-pressure and the
//            optional writable table (STRIP_TABLE_WR_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_strip_id_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [3:0]  req_addr_i;
    logic        req_ready_o;
    logic        abort_i;
    logic        cand_valid_o;
    logic        cand_ready_i;
    logic [3:0]  cand_id_o;
    logic [1:0]  cand_slot_o;
    logic        cand_last_o;
    logic        done_o;
    logic        miss_o;
`ifdef STRIP_TABLE_WR_EN
    logic        tbl_wr_en_i;
    logic [3:0]  tbl_wr_addr_i;
    logic [11:0] tbl_wr_data_i;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    strip_id_sequencer dut (
        .clk          (clk),
        .rst          (rst),
`ifdef STRIP_TABLE_WR_EN
        .tbl_wr_en_i  (tbl_wr_en_i),
        .tbl_wr_addr_i(tbl_wr_addr_i),
        .tbl_wr_data_i(tbl_wr_data_i),
`endif
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .req_ready_o  (req_ready_o),
        .abort_i      (abort_i),
        .cand_valid_o (cand_valid_o),
        .cand_ready_i (cand_ready_i),
        .cand_id_o    (cand_id_o),
        .cand_slot_o  (cand_slot_o),
        .cand_last_o  (cand_last_o),
        .done_o       (done_o),
        .miss_o       (miss_o)
    );

    // One vector = inputs for a cycle and the outputs expected in that cycle.
    typedef struct {
        bit       r;
        bit       rv;
        bit [3:0] addr;
        bit       ab;
        bit       cr;
        bit       chk;
        bit       ev;
        bit [3:0] eid;
        bit [1:0] eslot;
        bit       elast;
        bit       edone;
        bit       emiss;
        bit       erdy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit r, bit rv, int addr, bit ab, bit cr,
                                bit chk, bit ev, int eid, int eslot, bit elast,
                                bit edone, bit emiss, bit erdy);
        vec_t v;
        v.r = r; v.rv = rv; v.addr = 4'(addr); v.ab = ab; v.cr = cr;
        v.chk = chk; v.ev = ev; v.eid = 4'(eid); v.eslot = 2'(eslot);
        v.elast = elast; v.edone = edone; v.emiss = emiss; v.erdy = erdy;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Issue one request and follow it to done, comparing each accepted
    // candidate to the expected list. wr_cyc selects the cycle (0 = request
    // cycle, 1 = LOOKUP, 2 = first EMIT ...) carrying a table write.
    task automatic do_request(input string nm, input int addr, input int n,
                              input int e0, input int e1, input int e2,
                              input bit rnd, input int wr_cyc,
                              input int wr_addr, input int wr_data);
        int  exp_ids[3];
        int  k;
        bit  seen_done;
        exp_ids   = '{e0, e1, e2};
        k         = 0;
        seen_done = 1'b0;
        @(negedge clk);
        check({nm, " req_ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_addr_i   = 4'(addr);
        cand_ready_i = 1'b1;
`ifdef STRIP_TABLE_WR_EN
        tbl_wr_en_i   = (wr_cyc == 0);
        tbl_wr_addr_i = 4'(wr_addr);
        tbl_wr_data_i = 12'(wr_data);
`endif
        for (int j = 1; j <= 40 && !seen_done; j++) begin
            @(negedge clk);
            req_valid_i  = 1'b0;
            cand_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef STRIP_TABLE_WR_EN
            tbl_wr_en_i  = (wr_cyc == j);
`endif
            if (done_o) begin
                seen_done = 1'b1;
                check({nm, " miss"}, 32'(miss_o), 32'(n == 0));
                check({nm, " count"}, 32'(k), 32'(n));
            end else if (cand_valid_o && cand_ready_i) begin
                if (k < n) begin
                    check($sformatf("%s id%0d", nm, k), 32'(cand_id_o), 32'(exp_ids[k]));
                    check($sformatf("%s last%0d", nm, k), 32'(cand_last_o), 32'(k == n - 1));
                end else begin
                    check($sformatf("%s extra_cand", nm), 32'(cand_id_o), 32'hFFFF_FFFF);
                end
                k++;
            end
        end
        if (!seen_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: actual=no_done required=done", nm);
        end
        cand_ready_i = 1'b1;
`ifdef STRIP_TABLE_WR_EN
        tbl_wr_en_i  = 1'b0;
`endif
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bound the whole run in case the DUT stalls outside a checked wait.
    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        abort_i      = 1'b0;
        cand_ready_i = 1'b0;
`ifdef STRIP_TABLE_WR_EN
        tbl_wr_en_i   = 1'b0;
        tbl_wr_addr_i = '0;
        tbl_wr_data_i = '0;
`endif

        //           r  rv addr ab cr | chk ev id slot last done miss rdy
        vq.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1));
        // row 0 = 97D: 9, 7 then done
        vq.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 9, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 7, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 0, 0));
        // row 3 = 301: 0 is a valid code
        vq.push_back(mk(0, 1, 3, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 3, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 0, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 1, 2, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 0, 0));
        // row 8 = 8DD with 4 cycles of back-pressure
        vq.push_back(mk(0, 1, 8, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, 8, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, 8, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, 8, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,   1, 1, 8, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 8, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 0, 0));
        // addr 12 out of range: miss at cycle 2, ready at cycle 3
        vq.push_back(mk(0, 1, 12, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 1, 0));
        // row 9 = ABC, abort together with the second handshake
        vq.push_back(mk(0, 1, 9, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 10, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 1,   1, 1, 11, 1, 0, 0, 0, 0));
        // back in IDLE, no done; row 4 = 012
        vq.push_back(mk(0, 1, 4, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 1, 2, 2, 1, 0, 0, 0));
        // abort in FIN and IDLE is ignored
        vq.push_back(mk(0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 1, 5, 1, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        // abort in LOOKUP
        vq.push_back(mk(0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        // rst during EMIT of row 1 = 75D
        vq.push_back(mk(0, 1, 1, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 1,   1, 1, 7, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (vq[i].chk) begin
                check($sformatf("v%0d cand_valid", i), 32'(cand_valid_o), 32'(vq[i].ev));
                check($sformatf("v%0d done", i), 32'(done_o), 32'(vq[i].edone));
                check($sformatf("v%0d miss", i), 32'(miss_o), 32'(vq[i].emiss));
                check($sformatf("v%0d req_ready", i), 32'(req_ready_o), 32'(vq[i].erdy));
                if (vq[i].ev) begin
                    check($sformatf("v%0d cand_id", i), 32'(cand_id_o), 32'(vq[i].eid));
                    check($sformatf("v%0d cand_slot", i), 32'(cand_slot_o), 32'(vq[i].eslot));
                    check($sformatf("v%0d cand_last", i), 32'(cand_last_o), 32'(vq[i].elast));
                end
            end
            rst          = vq[i].r;
            req_valid_i  = vq[i].rv;
            req_addr_i   = vq[i].addr;
            abort_i      = vq[i].ab;
            cand_ready_i = vq[i].cr;
        end
        abort_i = 1'b0;

        // Held candidate under back-pressure, then reset clears every output.
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_addr_i   = 4'd2;
        cand_ready_i = 1'b0;
        @(negedge clk);
        req_valid_i  = 1'b0;
        @(negedge clk);
        check("hold id", 32'(cand_id_o), 32'd5);
        @(negedge clk);
        check("hold id2", 32'(cand_id_o), 32'd5);
        check("hold valid", 32'(cand_valid_o), 32'd1);
        check("hold last", 32'(cand_last_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst cand_valid", 32'(cand_valid_o), 32'd0);
        check("rst cand_id", 32'(cand_id_o), 32'd0);
        check("rst cand_slot", 32'(cand_slot_o), 32'd0);
        check("rst cand_last", 32'(cand_last_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst miss", 32'(miss_o), 32'd0);
        check("rst req_ready", 32'(req_ready_o), 32'd1);
        cand_ready_i = 1'b1;

        // Random back-pressure on complete sequences.
        do_request("rnd_row6", 6, 2, 4, 6, 0, 1'b1, -1, 0, 0);
        do_request("rnd_row7", 7, 2, 6, 8, 0, 1'b1, -1, 0, 0);
        do_request("rnd_row3", 3, 3, 3, 0, 1, 1'b1, -1, 0, 0);
        do_request("rnd_row15", 15, 0, 0, 0, 0, 1'b1, -1, 0, 0);

`ifdef STRIP_TABLE_WR_EN
        // Write during EMIT leaves the latched row alone.
        do_request("wr_emit", 5, 2, 2, 4, 0, 1'b0, 2, 5, 12'h1DD);
        // LOOKUP sees the new row; a same-cycle write is not yet visible.
        do_request("wr_new", 5, 1, 1, 0, 0, 1'b0, 1, 5, 12'h24D);
        do_request("wr_landed", 5, 2, 2, 4, 0, 1'b0, -1, 0, 0);
        // Out-of-range write is dropped.
        do_request("wr_oob", 12, 0, 0, 0, 0, 1'b0, 0, 12, 12'h123);
        // Write before LOOKUP is seen; reset restores the default row.
        do_request("wr_early", 5, 1, 1, 0, 0, 1'b0, 0, 5, 12'h1DD);
        pulse_reset();
        do_request("wr_rst", 5, 2, 2, 4, 0, 1'b0, -1, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
